apb3_timer_slave: RTL
=====================

Name: apb3_timer_slave

Overview:
- APB3 completer (responder) holding a small register bank and a 32-bit down-counter timer with an interrupt output.
- Sits on the APB3 side of the AHB-to-APB3 bridge and is driven by its PSEL/PENABLE/PADDR/PWRITE/PWDATA.
- Returns PRDATA/PREADY/PSLVERR with a configurable number of wait states.
- Serves as the team's standard APB peripheral template for the FPGA fabric.

Parameters:
- ADDR_WIDTH, 8, number of PADDR bits decoded; upper bits are ignored.
- WAIT_STATES, 1, cycles PREADY is held low in the access phase (0..15).
- PRESCALE, 1, number of HCLK cycles per counter decrement (1..65535).

Ports:
- HCLK  in  1  single clock shared with the bridge.
- HRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PADDR  in  32  byte address; only [ADDR_WIDTH-1:0] is decoded.
- PWRITE  in  1  1 = write.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid only while PREADY=1.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response; valid only while PREADY=1.
- IRQ  out  1  level interrupt.

Behaviour:
- Reset (async, HRESET=1):
  - Outputs: PRDATA=0, PREADY=0, PSLVERR=0, IRQ=0.
  - Registers: CTRL=0, LOAD=0, VALUE=0, STATUS=0, SCRATCH=0.
  - FSM goes to IDLE; wait counter and prescaler are cleared.
  - Reset asserted mid-transfer aborts the transfer with no register side effect.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSEL=1 and PENABLE=0.
  - SETUP -> ACCESS on the next cycle. Wait counter loads WAIT_STATES.
  - ACCESS: PREADY=0 while the wait counter is nonzero; it decrements each cycle.
  - When the counter reaches 0, PREADY=1 for exactly one cycle, then the FSM returns to IDLE.
  - If PSEL drops during ACCESS (protocol violation), return to IDLE with no side effect.
  - Back-to-back transfers: IDLE sees the new SETUP on the cycle after PREADY.
  - With WAIT_STATES=0, PREADY=1 on the first ACCESS cycle.
- Completion cycle: register side effects, PRDATA and PSLVERR occur only in the cycle where PSEL & PENABLE & PREADY are all 1. PRDATA=0 in every other cycle.
- Register map (word offsets):
  - 0x00 CTRL, RW: [0] EN, [1] RELOAD, [2] IRQ_EN; other bits read 0.
  - 0x04 LOAD, RW: a write also copies PWDATA into VALUE and clears the prescaler.
  - 0x08 VALUE, RO.
  - 0x0C STATUS: [0] EXPIRED, write-1-to-clear.
  - 0x10 SCRATCH, RW, 32 bits.
- Error response (PSLVERR=1 at completion, no side effect, PRDATA=0) for:
  - unmapped offset;
  - PADDR[1:0]!=0;
  - write to VALUE.
- Timer:
  - While EN=1, the prescaler counts 0..PRESCALE-1; on wrap, the tick fires.
  - On a tick with VALUE!=0: VALUE decrements by 1.
  - On a tick with VALUE==0: EXPIRED<=1; if RELOAD=1, VALUE<=LOAD; else EN<=0 (hardware clear) and VALUE stays 0.
  - EN=0 freezes both VALUE and the prescaler.
- Simultaneous events:
  - Hardware set of EXPIRED and a W1C in the same cycle: the set wins (EXPIRED=1).
  - Hardware EN clear and a CTRL write in the same cycle: the software write wins.
  - LOAD write and a tick in the same cycle: the LOAD write wins (VALUE=PWDATA).
- IRQ is registered: IRQ <= EXPIRED & IRQ_EN (one-cycle latency after either changes).

Test Plan:
- Reset, then read SCRATCH with WAIT_STATES=1 -> PREADY low for 1 ACCESS cycle, then high for 1 cycle; PRDATA=0x00000000, PSLVERR=0.
- Write SCRATCH=0xA5A5_5A5A, read it back -> PRDATA=0xA5A5_5A5A on the PREADY cycle; PRDATA=0 on all other cycles.
- PRESCALE=1: write LOAD=3, then CTRL=0x5 (EN, IRQ_EN, one-shot):
  - VALUE reads 3,2,1,0 on successive ticks;
  - the next tick sets EXPIRED=1 and clears EN;
  - IRQ rises 1 cycle later;
  - W1C STATUS=0x1 drops IRQ the cycle after completion.
- RELOAD=1, LOAD=2 -> VALUE sequence 2,1,0,2,1,0; EXPIRED stays set and EN stays 1.
- Write VALUE, access offset 0x14, and access 0x02 -> each returns PSLVERR=1 and PRDATA=0; all registers are unchanged.
- Assert HRESET during ACCESS of a SCRATCH write -> PREADY=0 immediately and SCRATCH=0 after reset; a W1C in the same cycle as a hardware expiry leaves EXPIRED=1.

Source files
------------

// File: rtl/apb3_timer_slave.sv
// APB3 completer with a small register bank and a prescaled 32-bit down-counter
// that raises a level interrupt when it expires.
module apb3_timer_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1,
  parameter int PRESCALE    = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [3:0]            WAIT_INIT   = 4'(WAIT_STATES);
  localparam logic [15:0]           PRESC_LAST  = 16'(PRESCALE - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL    = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] OFF_LOAD    = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] OFF_VALUE   = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS  = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] OFF_SCRATCH = ADDR_WIDTH'(8'h10);

  state_t        state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic          pready_q, pready_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [31:0]   load_q, load_d;
  logic [31:0]   value_q, value_d;
  logic          expired_q, expired_d;
  logic [31:0]   scratch_q, scratch_d;
  logic [15:0]   presc_q, presc_d;
  logic          irq_q, irq_d;

  logic [ADDR_WIDTH-1:0] addr;
  logic hit_ctrl, hit_load, hit_value, hit_status, hit_scratch;
  logic err, done, wr_ok, rd_ok, tick, expire_hw;
  logic [31:0] rdata;

  if (ADDR_WIDTH < 32) begin : g_unused
    logic unused_paddr_hi;
    assign unused_paddr_hi = ^PADDR[31:ADDR_WIDTH];
  end

  // Handshake: a transfer completes only in the cycle where PSEL, PENABLE and
  // PREADY are all high; side effects, PRDATA and PSLVERR exist only there.
  assign addr        = PADDR[ADDR_WIDTH-1:0];
  assign hit_ctrl    = (addr == OFF_CTRL);
  assign hit_load    = (addr == OFF_LOAD);
  assign hit_value   = (addr == OFF_VALUE);
  assign hit_status  = (addr == OFF_STATUS);
  assign hit_scratch = (addr == OFF_SCRATCH);
  assign err   = (addr[1:0] != 2'b00)
               | ~(hit_ctrl | hit_load | hit_value | hit_status | hit_scratch)
               | (PWRITE & hit_value);
  assign done  = PSEL & PENABLE & pready_q;
  assign wr_ok = done & PWRITE & ~err;
  assign rd_ok = done & ~PWRITE & ~err;

  always_comb begin
    rdata = 32'h0;
    if (hit_ctrl)         rdata = {29'h0, ctrl_q};
    else if (hit_load)    rdata = load_q;
    else if (hit_value)   rdata = value_q;
    else if (hit_status)  rdata = {31'h0, expired_q};
    else if (hit_scratch) rdata = scratch_q;
  end

  assign PRDATA  = rd_ok ? rdata : 32'h0;
  assign PSLVERR = done & err;
  assign PREADY  = pready_q;
  assign IRQ     = irq_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
          wait_d  = WAIT_INIT;
        end
      end
      ST_ACCESS: begin
        if (!PSEL || pready_q) begin
          state_d = ST_IDLE;
          wait_d  = 4'd0;
        end else if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pready_d = (state_d == ST_ACCESS) && (wait_d == 4'd0);
  end

  // Hardware timer updates first; software writes below override them.
  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    value_d   = value_q;
    expired_d = expired_q;
    scratch_d = scratch_q;
    presc_d   = presc_q;
    expire_hw = 1'b0;
    tick      = ctrl_q[0] && (presc_q == PRESC_LAST);

    if (ctrl_q[0]) presc_d = tick ? 16'h0 : presc_q + 16'd1;
    if (tick) begin
      if (value_q != 32'h0) begin
        value_d = value_q - 32'd1;
      end else begin
        expire_hw = 1'b1;
        if (ctrl_q[1]) value_d   = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    if (wr_ok) begin
      if (hit_ctrl) ctrl_d = PWDATA[2:0];
      if (hit_load) begin
        load_d  = PWDATA;
        value_d = PWDATA;
        presc_d = 16'h0;
      end
      if (hit_status && PWDATA[0]) expired_d = 1'b0;
      if (hit_scratch) scratch_d = PWDATA;
    end
    // A hardware expiry beats a same-cycle write-1-to-clear.
    if (expire_hw) expired_d = 1'b1;

    irq_d = expired_q & ctrl_q[2];
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      wait_q    <= 4'd0;
      pready_q  <= 1'b0;
      ctrl_q    <= 3'd0;
      load_q    <= 32'h0;
      value_q   <= 32'h0;
      expired_q <= 1'b0;
      scratch_q <= 32'h0;
      presc_q   <= 16'h0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      pready_q  <= pready_d;
      ctrl_q    <= ctrl_d;
      load_q    <= load_d;
      value_q   <= value_d;
      expired_q <= expired_d;
      scratch_q <= scratch_d;
      presc_q   <= presc_d;
      irq_q     <= irq_d;
    end
  end

endmodule
